// File: rtl/mempool_pkg.sv
// rtl/mempool_pkg.sv - shared MemPool types and constants used by the TCDM master pipe
package mempool_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned BeWidth   = DataWidth / 8;

  // Default bound on reads in flight per tile bank lane
  localparam int unsigned TCDMMaxOutstanding = 4;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [BeWidth-1:0]   be_t;

endpackage

// File: rtl/tcdm_spill_buffer.sv
// rtl/tcdm_spill_buffer.sv - generic two-entry valid/ready FIFO, breaks the ready path
module tcdm_spill_buffer #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  T           mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  // ready depends only on local occupancy, so no path from ready_i to ready_o
  assign ready_o = (count != 2'd2);
  assign valid_o = (count != 2'd0);
  assign data_o  = mem[rd_ptr];
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  // Storage, pointers and occupancy; simultaneous push and pop keep the count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/tcdm_master_pipe.sv
// rtl/tcdm_master_pipe.sv - registered request stage with read credit limit; TCDM_PIPE_RSP_REG_EN registers the response
module tcdm_master_pipe
  import mempool_pkg::*;
#(
  parameter int unsigned MaxOutstanding = TCDMMaxOutstanding,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  req_i,
  input  addr_t addr_i,
  input  logic  wen_i,
  input  data_t wdata_i,
  input  be_t   be_i,
  output logic  gnt_o,
  output logic  vld_o,
  output data_t rdata_o,
  output logic  req_o,
  output addr_t addr_o,
  output logic  wen_o,
  output data_t wdata_o,
  output be_t   be_o,
  input  logic  gnt_i,
  input  logic  vld_i,
  input  data_t rdata_i
);

  typedef struct packed {
    addr_t addr;
    logic  wen;
    data_t wdata;
    be_t   be;
  } req_t;

  req_t                in_req;
  req_t                out_req;
  logic                buf_ready;
  logic                credit_ok;
  logic                rd_inc;
  logic                rd_dec;
  logic [CntWidth-1:0] rd_cnt;

  assign in_req = '{addr: addr_i, wen: wen_i, wdata: wdata_i, be: be_i};

  // Writes bypass the credit check; reads need a free slot in the budget
  assign credit_ok = wen_i | (rd_cnt != CntWidth'(MaxOutstanding));
  assign gnt_o     = buf_ready & credit_ok;

  tcdm_spill_buffer #(
    .T (req_t)
  ) i_spill (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (req_i & credit_ok),
    .ready_o (buf_ready),
    .data_i  (in_req),
    .valid_o (req_o),
    .ready_i (gnt_i),
    .data_o  (out_req)
  );

  assign addr_o  = out_req.addr;
  assign wen_o   = out_req.wen;
  assign wdata_o = out_req.wdata;
  assign be_o    = out_req.be;

  // Stray responses (e.g. for requests issued before reset) must not underflow
  assign rd_inc = req_i & gnt_o & ~wen_i;
  assign rd_dec = vld_i & (rd_cnt != '0);

  // Reads in flight: +1 on accepted read, -1 on downstream response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cnt <= '0;
    end else if (rd_inc && !rd_dec) begin
      rd_cnt <= rd_cnt + 1'b1;
    end else if (rd_dec && !rd_inc) begin
      rd_cnt <= rd_cnt - 1'b1;
    end
  end

`ifdef TCDM_PIPE_RSP_REG_EN
  // One-cycle response register; data only captured on a valid beat
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      vld_o <= vld_i;
      if (vld_i) begin
        rdata_o <= rdata_i;
      end
    end
  end
`else
  assign vld_o   = vld_i;
  assign rdata_o = rdata_i;
`endif

endmodule

// File: tb/tb_tcdm_master_pipe.sv
// tb/tb_tcdm_master_pipe.sv - randomized self-checking bench for tcdm_master_pipe
module tb_tcdm_master_pipe;
  import mempool_pkg::*;

  localparam int MAX = 4;

  typedef struct {
    addr_t addr;
    logic  wen;
    data_t wdata;
    be_t   be;
  } exp_req_t;

  logic  clk = 1'b0;
  logic  rst_i;
  logic  req_i;
  addr_t addr_i;
  logic  wen_i;
  data_t wdata_i;
  be_t   be_i;
  logic  gnt_o;
  logic  vld_o;
  data_t rdata_o;
  logic  req_o;
  addr_t addr_o;
  logic  wen_o;
  data_t wdata_o;
  be_t   be_o;
  logic  gnt_i;
  logic  vld_i;
  data_t rdata_i;

  int n_pass  = 0;
  int n_check = 0;

  // Reference state: ordered list of requests waiting downstream, reads in flight
  exp_req_t mq[$];
  int       m_cnt = 0;
  logic     m_prev_vld = 1'b0;
  data_t    m_last_rdata = '0;

  always #5 clk = ~clk;

  tcdm_master_pipe #(.MaxOutstanding(MAX)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .addr_i  (addr_i),
    .wen_i   (wen_i),
    .wdata_i (wdata_i),
    .be_i    (be_i),
    .gnt_o   (gnt_o),
    .vld_o   (vld_o),
    .rdata_o (rdata_o),
    .req_o   (req_o),
    .addr_o  (addr_o),
    .wen_o   (wen_o),
    .wdata_o (wdata_o),
    .be_o    (be_o),
    .gnt_i   (gnt_i),
    .vld_i   (vld_i),
    .rdata_i (rdata_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_check++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_cnt        = 0;
    m_prev_vld   = 1'b0;
    m_last_rdata = '0;
  endtask

  // One cycle: drive inputs after the falling edge, check outputs, advance the model.
  // exp_g >= 0 adds a directed expectation on gnt_o for this cycle.
  task automatic step(input logic rq, input logic w, input logic gi, input logic vi, input int exp_g);
    logic m_gnt;
    logic do_pop;
    @(negedge clk);
    req_i   = rq;
    wen_i   = w;
    addr_i  = $urandom;
    wdata_i = $urandom;
    be_i    = be_t'($urandom);
    gnt_i   = gi;
    vld_i   = vi;
    rdata_i = $urandom;
    #1;
    m_gnt = (mq.size() < 2) && (w || m_cnt < MAX);
    check("gnt_o", gnt_o, m_gnt);
    if (exp_g >= 0) check("gnt_directed", gnt_o, (exp_g != 0));
    check("req_o", req_o, mq.size() != 0);
    if (mq.size() != 0) begin
      check("addr_o", addr_o, mq[0].addr);
      check("wen_o", wen_o, mq[0].wen);
      check("wdata_o", wdata_o, mq[0].wdata);
      check("be_o", be_o, mq[0].be);
    end
`ifdef TCDM_PIPE_RSP_REG_EN
    check("vld_o", vld_o, m_prev_vld);
    if (m_prev_vld) check("rdata_o", rdata_o, m_last_rdata);
    m_prev_vld = vi;
    if (vi) m_last_rdata = rdata_i;
`else
    check("vld_o", vld_o, vi);
    if (vi) check("rdata_o", rdata_o, rdata_i);
`endif
    do_pop = (mq.size() != 0) && gi;
    if (do_pop) void'(mq.pop_front());
    if (rq && m_gnt) mq.push_back('{addr: addr_i, wen: w, wdata: wdata_i, be: be_i});
    if (vi && m_cnt > 0) m_cnt = m_cnt - 1 + ((rq && m_gnt && !w) ? 1 : 0);
    else                 m_cnt = m_cnt + ((rq && m_gnt && !w) ? 1 : 0);
  endtask

  initial begin
    rst_i = 1'b1; req_i = 0; wen_i = 0; addr_i = '0; wdata_i = '0; be_i = '0;
    gnt_i = 0; vld_i = 0; rdata_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt_o", gnt_o, 1'b1);
    check("rst_req_o", req_o, 1'b0);
    check("rst_vld_o", vld_o, 1'b0);
    check("rst_rdata_o", rdata_o, '0);
    check("rst_addr_o", addr_o, '0);
    check("rst_wdata_o", wdata_o, '0);
    check("rst_be_o", be_o, '0);
    check("rst_wen_o", wen_o, 1'b0);
    rst_i = 1'b0;

    // Streaming writes with the interconnect always granting
    for (int i = 0; i < 16; i++) step(1, 1, 1, 0, 1);
    step(0, 0, 1, 0, -1);

    // Backpressure: two entries buffered, then upstream grant drops
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, (i < 2) ? 1 : 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, -1);

    // Credit limit: only MAX reads accepted, writes still pass
    for (int i = 0; i < 6; i++) step(1, 0, 1, 0, (i < MAX) ? 1 : 0);
    step(1, 1, 1, 0, 1);
    step(0, 0, 1, 1, -1);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 0, 0);

    // Simultaneous read accept and response at count 3 keeps the count
    step(0, 0, 1, 1, -1);
    step(1, 0, 1, 1, 1);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 0, 0);

    // Drain credits, then park two reads and reset mid-operation
    for (int i = 0; i < MAX; i++) step(0, 0, 1, 1, -1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    @(negedge clk);
    req_i = 0; gnt_i = 0; vld_i = 0;
    #1 rst_i = 1'b1;
    #1;
    check("midrst_req_o", req_o, 1'b0);
    check("midrst_gnt_o", gnt_o, 1'b1);
    model_reset();
    @(negedge clk);
    rst_i = 1'b0;
    step(0, 0, 1, 1, -1);
    for (int i = 0; i < MAX + 1; i++) step(1, 0, 1, 0, (i < MAX) ? 1 : 0);
    for (int i = 0; i < MAX; i++) step(0, 0, 1, 1, -1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
